// File: rtl/axi_fifo_pkg.sv
// Shared types and constants for the AXI channel buffer.
package axi_fifo_pkg;

    localparam int unsigned AXI_FIFO_DW    = 71;
    localparam int unsigned AXI_FIFO_DEPTH = 8;

    typedef logic [AXI_FIFO_DW-1:0] axi_fifo_data_t;

endpackage

// File: rtl/axi_fifo_entry.sv
// Single buffer entry: captures the shared write bus when its create enable is set.
module axi_fifo_entry
    import axi_fifo_pkg::*;
(
    input  logic           entry_clk,
    input  logic           entry_rst_b,
    input  logic           create_en,
    input  axi_fifo_data_t data_in,
    output axi_fifo_data_t data_out
);

    always_ff @(posedge entry_clk or negedge entry_rst_b) begin
        if (!entry_rst_b) begin
            data_out <= '0;
        end else if (create_en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/axi_fifo_ctrl.sv
// Pointer/flow-control sequencer over DEPTH axi_fifo_entry registers.
// Status flags are pure decodes of the registered pointers, so they move only on clock or reset.
module axi_fifo_ctrl
    import axi_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = AXI_FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             fifo_clk,
    input  logic             fifo_rst_b,
    input  logic             push_vld,
    input  axi_fifo_data_t   push_data,
    output logic             push_rdy,
    output logic             pop_vld,
    output axi_fifo_data_t   pop_data,
    input  logic             pop_rdy,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             fifo_full,
    output logic             fifo_empty
);

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             push_fire;
    logic             pop_fire;
    logic [DEPTH-1:0] create_en;
    axi_fifo_data_t   entry_q [DEPTH];

    // Pointer MSB is the wrap bit; equal indices with differing wrap bits means full.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                        (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign push_rdy   = !fifo_full;
    assign pop_vld    = !fifo_empty;
    assign push_fire  = push_vld && push_rdy;
    assign pop_fire   = pop_vld && pop_rdy;
    assign pop_data   = entry_q[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge fifo_clk or negedge fifo_rst_b) begin
        if (!fifo_rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // One-hot create decode; every entry sees the same write bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign create_en[i] = push_fire && (wr_ptr[PTR_W-1:0] == PTR_W'(i));

        axi_fifo_entry u_entry (
            .entry_clk   (fifo_clk),
            .entry_rst_b (fifo_rst_b),
            .create_en   (create_en[i]),
            .data_in     (push_data),
            .data_out    (entry_q[i])
        );
    end

endmodule

// File: tb/tb_axi_fifo_ctrl.sv
// Directed bench for axi_fifo_ctrl with a queue-based reference model.
module tb_axi_fifo_ctrl;
    import axi_fifo_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             push_vld;
    axi_fifo_data_t   push_data;
    logic             push_rdy;
    logic             pop_vld;
    axi_fifo_data_t   pop_data;
    logic             pop_rdy;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;

    int n_vec = 0;
    int n_err = 0;

    axi_fifo_data_t model_q[$];

    axi_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .fifo_clk   (clk),
        .fifo_rst_b (rst_n),
        .push_vld   (push_vld),
        .push_data  (push_data),
        .push_rdy   (push_rdy),
        .pop_vld    (pop_vld),
        .pop_data   (pop_data),
        .pop_rdy    (pop_rdy),
        .fifo_cnt   (fifo_cnt),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue; a beat enters when there is room, leaves when present and taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit do_push = push_vld && (model_q.size() < DEPTH);
            automatic bit do_pop  = pop_rdy && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(push_data);
        end
    end

    always @(negedge clk) begin
        check("model_rdy",   72'(push_rdy),   72'(model_q.size() < DEPTH));
        check("model_vld",   72'(pop_vld),    72'(model_q.size() > 0));
        check("model_cnt",   72'(fifo_cnt),   72'(model_q.size()));
        check("model_full",  72'(fifo_full),  72'(model_q.size() == DEPTH));
        check("model_empty", 72'(fifo_empty), 72'(model_q.size() == 0));
        if (model_q.size() > 0) begin
            check("model_data", 72'(pop_data), 72'(model_q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        push_vld  = 1'b0;
        pop_rdy   = 1'b0;
        push_data = '0;
        step();
        step();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_empty", 72'(fifo_empty), 72'(1));
        check("rst_cnt",   72'(fifo_cnt),   72'(0));
        check("rst_rdy",   72'(push_rdy),   72'(1));
        check("rst_vld",   72'(pop_vld),    72'(0));
        check("rst_data",  72'(pop_data),   72'(0));
        step();

        // Fill 1..8, then hold a 9th beat against a full buffer.
        push_vld = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push_data = axi_fifo_data_t'(i);
            step();
        end
        push_data = axi_fifo_data_t'(9);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fill_cnt",  72'(fifo_cnt),  72'(8));
            check("fill_full", 72'(fifo_full), 72'(1));
            check("fill_rdy",  72'(push_rdy),  72'(0));
            check("fill_head", 72'(pop_data),  72'(1));
            step();
        end
        push_vld = 1'b0;

        // Drain in order.
        pop_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("drain_data", 72'(pop_data), 72'(i));
            step();
        end
        @(negedge clk);
        check("drain_empty", 72'(fifo_empty), 72'(1));
        check("drain_vld",   72'(pop_vld),    72'(0));

        // Empty: no bypass from push to pop.
        step();
        push_vld  = 1'b1;
        push_data = axi_fifo_data_t'(72'h55);
        @(negedge clk);
        check("nobyp_vld0", 72'(pop_vld), 72'(0));
        step();
        push_vld = 1'b0;
        @(negedge clk);
        check("nobyp_vld1", 72'(pop_vld),  72'(1));
        check("nobyp_data", 72'(pop_data), 72'(72'h55));
        step();
        @(negedge clk);
        check("nobyp_cnt", 72'(fifo_cnt), 72'(0));
        step();

        // Bring to 4 entries, then push and pop together for 20 cycles.
        pop_rdy  = 1'b0;
        push_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_data = axi_fifo_data_t'(72'h100 + 72'(i));
            step();
        end
        pop_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_data = axi_fifo_data_t'(72'h200 + 72'(i));
            @(negedge clk);
            check("sim_cnt", 72'(fifo_cnt), 72'(4));
            if (i < 4) check("sim_data", 72'(pop_data), 72'(72'h100 + 72'(i)));
            else       check("sim_data", 72'(pop_data), 72'(72'h200 + 72'(i - 4)));
            step();
        end

        // Top up to full, then pop while a push is pending.
        pop_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_data = axi_fifo_data_t'(72'h300 + 72'(i));
            step();
        end
        push_data = axi_fifo_data_t'(72'h3aa);
        pop_rdy   = 1'b1;
        @(negedge clk);
        check("fp_cnt8", 72'(fifo_cnt), 72'(8));
        check("fp_rdy0", 72'(push_rdy), 72'(0));
        step();
        pop_rdy = 1'b0;
        @(negedge clk);
        check("fp_cnt7", 72'(fifo_cnt), 72'(7));
        check("fp_rdy1", 72'(push_rdy), 72'(1));
        step();
        push_vld = 1'b0;
        @(negedge clk);
        check("fp_back8", 72'(fifo_cnt), 72'(8));

        // Reduce to 3 entries, then reset mid-cycle.
        pop_rdy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        pop_rdy  = 1'b0;
        push_vld = 1'b1;
        push_data = axi_fifo_data_t'(72'h777);
        @(negedge clk);
        check("pre_rst_cnt", 72'(fifo_cnt), 72'(3));
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_empty", 72'(fifo_empty), 72'(1));
        check("mrst_cnt",   72'(fifo_cnt),   72'(0));
        check("mrst_rdy",   72'(push_rdy),   72'(1));
        check("mrst_vld",   72'(pop_vld),    72'(0));
        check("mrst_data",  72'(pop_data),   72'(0));
        push_vld = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
